hm_ctlif: RTL and testbench
===========================

Name: hm_ctlif

Overview:
- sys_clk-domain control/status interface of the hm core; sits directly downstream of the trn→sys synchroniser and consumes its sys__* outputs.
- Decodes the CSR bus and exposes synchronised state, statistics and event pulses as registers.
- Accumulates sticky event flags and saturating event counters, and drives the irq output.
- Drives the two sys→trn controls, sys__hm_start_read (pulse) and sys__bar_bitmap (level), back into the synchroniser.

Parameters:
- csr_addr, 4'h0, CSR bank select compared against csr_a[13:10].
- cnt_w, 16, width of each event counter; 2*cnt_w must be ≤ 32.

Ports:
- sys_clk  in  1  system clock; all logic single-domain.
- sys_rst  in  1  asynchronous, active-high reset.
- csr_a  in  14  CSR address; [13:10] bank, [3:0] register.
- csr_we  in  1  CSR write strobe.
- csr_di  in  32  CSR write data.
- csr_do  out  32  CSR read data.
- irq  out  1  level interrupt.
- sys__rx_timeout, sys__tx_timeout, sys__wr_timeout, sys__hm_end, sys__write_bar, sys__read_exp  in  1 each  single-cycle event pulses.
- sys__trn_lnk_up_n  in  1  synchronised link-up, active-low level.
- sys__state_rx  in  3  rx FSM state.
- sys__state_tx  in  2  tx FSM state.
- sys__state  in  2  top FSM state; 0 = idle.
- sys__rx_tlp_dw  in  32  last rx TLP dword.
- sys__write_bar_number  in  5  BAR index accompanying sys__write_bar.
- sys__stat_trn_cpt_rx, sys__stat_trn_cpt_tx, sys__stat_trn_cpt_tx_drop, sys__stat_trn_cpt_tx_start, sys__tx_error  in  32 each  statistics.
- sys__bar_bitmap  out  32  BAR enable bitmap.
- sys__hm_start_read  out  1  start pulse to trn domain.

Behaviour:
- Reset values: every output 0; all registers 0.
- Select: sel = (csr_a[13:10] == csr_addr).
- Read path: csr_do is registered, data valid one cycle after address; csr_do = 0 in the cycle after a non-selected address.
- Register map (csr_a[3:0]):
  - 0 CTRL: W bit0=1 requests start. R bit0 = busy (sys__state != 0).
  - 1 STATUS: sticky bits. 0 rx_to, 1 tx_to, 2 wr_to, 3 hm_end, 4 write_bar, 5 read_exp, 6 link_down, 7 start_rej. Write-1-to-clear.
  - 2 IRQ_EN: RW, bits 7:0.
  - 3 STATE: R {24'b0, state[1:0], state_tx[1:0], state_rx[2:0], ~lnk_up_n}.
  - 4 BAR_BITMAP: RW, drives sys__bar_bitmap directly.
  - 5 LAST_BAR: R, 5 bits; captures sys__write_bar_number in the cycle sys__write_bar=1.
  - 6 RX_TLP_DW, 7 CPT_RX, 8 CPT_TX, 9 CPT_TX_DROP, A CPT_TX_START, B TX_ERROR: R passthrough.
  - C CNT0: R {tx_to_cnt, rx_to_cnt}; any write clears both.
  - D CNT1: R {hm_end_cnt, wr_to_cnt}; any write clears both.
  - E/F: read 0, writes ignored.
- Start handshake:
  - CTRL write with bit0=1 and busy=0 → sys__hm_start_read = 1 for exactly one cycle, the cycle after the write.
  - The same request while busy=1 → no pulse; STATUS[7] set.
  - A second request in the cycle directly after an accepted one is dropped silently (no pulse, no flag).
- link_down flag: set on the 0→1 edge of sys__trn_lnk_up_n, using a registered previous value that resets to 0.
- Counters: cnt_w bits wide, +1 per event pulse, saturate at all-ones; no wrap.
- Same-cycle conflicts:
  - Counter clear and event in the same cycle → counter = 1.
  - Event set and W1C in the same cycle → bit stays 1.
- irq: registered; irq = |(STATUS & IRQ_EN) from the previous cycle, so it asserts 1 cycle after the flag sets.
- Reset mid-operation: asynchronous; clears everything immediately, including a pending start pulse.

Decomposition:
- Shared package hm_pkg holds: register offsets, STATUS bit indices, and HM_STATE_IDLE = 2'd0.
- One sub-module, hm_evcnt: parameterised saturating counter with inc and clr inputs (clr+inc → 1). Instantiated four times.

Test Plan:
- Reset, then read regs 0–F → all 0 except the passthroughs, which equal their inputs; irq=0; sys__bar_bitmap=0.
- Write BAR_BITMAP=32'hA5A5_0003 → sys__bar_bitmap equals it next cycle; readback matches.
- sys__state=0, write CTRL=1 → exactly one sys__hm_start_read pulse. With sys__state=2, write CTRL=1 → no pulse, STATUS=8'h80.
- Pulse sys__rx_timeout 3×, sys__tx_timeout 1× → CNT0=32'h0001_0003. Then write CNT0 in the same cycle as an rx_timeout pulse → CNT0=32'h0000_0001.
- IRQ_EN=8'h08, pulse sys__hm_end → STATUS[3]=1 and irq=1 one cycle later. W1C 8'h08 → irq falls. W1C coinciding with a new hm_end → bit and irq stay 1.
- Drive 70000 wr_timeout pulses → CNT1[15:0]=16'hFFFF. Pulse write_bar with number 5'd17 → LAST_BAR=17, STATUS[4]=1. Raise lnk_up_n → STATUS[6]=1.

Source files
------------

// File: rtl/hm_pkg.sv
// Shared definitions for the hm control/status interface.
// Register offsets, STATUS bit layout and the top-FSM idle encoding.
package hm_pkg;

  localparam logic [3:0] REG_CTRL         = 4'h0;
  localparam logic [3:0] REG_STATUS       = 4'h1;
  localparam logic [3:0] REG_IRQ_EN       = 4'h2;
  localparam logic [3:0] REG_STATE        = 4'h3;
  localparam logic [3:0] REG_BAR_BITMAP   = 4'h4;
  localparam logic [3:0] REG_LAST_BAR     = 4'h5;
  localparam logic [3:0] REG_RX_TLP_DW    = 4'h6;
  localparam logic [3:0] REG_CPT_RX       = 4'h7;
  localparam logic [3:0] REG_CPT_TX       = 4'h8;
  localparam logic [3:0] REG_CPT_TX_DROP  = 4'h9;
  localparam logic [3:0] REG_CPT_TX_START = 4'hA;
  localparam logic [3:0] REG_TX_ERROR     = 4'hB;
  localparam logic [3:0] REG_CNT0         = 4'hC;
  localparam logic [3:0] REG_CNT1         = 4'hD;

  localparam int ST_RX_TO     = 0;
  localparam int ST_TX_TO     = 1;
  localparam int ST_WR_TO     = 2;
  localparam int ST_HM_END    = 3;
  localparam int ST_WRITE_BAR = 4;
  localparam int ST_READ_EXP  = 5;
  localparam int ST_LINK_DOWN = 6;
  localparam int ST_START_REJ = 7;

  localparam logic [1:0] HM_STATE_IDLE = 2'd0;

  // Field order matches the ST_* indices, bit 0 last.
  typedef struct packed {
    logic start_rej;
    logic link_down;
    logic read_exp;
    logic write_bar;
    logic hm_end;
    logic wr_to;
    logic tx_to;
    logic rx_to;
  } hm_status_t;

endpackage

// File: rtl/hm_evcnt.sv
// Saturating event counter; clear has priority but a coincident event leaves 1.
// Latency: count visible the cycle after inc; no backpressure.
module hm_evcnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = inc ? W'(1) : '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hm_ctlif.sv
// hm sys_clk CSR block: sticky events, saturating counters, irq and start handshake.
// Latency: csr_do/irq/start one cycle after their cause; no backpressure anywhere.
module hm_ctlif
  import hm_pkg::*;
#(
  parameter logic [3:0] csr_addr = 4'h0,
  parameter int         cnt_w    = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  output logic        irq,
  input  logic        sys__rx_timeout,
  input  logic        sys__tx_timeout,
  input  logic        sys__wr_timeout,
  input  logic        sys__hm_end,
  input  logic        sys__write_bar,
  input  logic        sys__read_exp,
  input  logic        sys__trn_lnk_up_n,
  input  logic [2:0]  sys__state_rx,
  input  logic [1:0]  sys__state_tx,
  input  logic [1:0]  sys__state,
  input  logic [31:0] sys__rx_tlp_dw,
  input  logic [4:0]  sys__write_bar_number,
  input  logic [31:0] sys__stat_trn_cpt_rx,
  input  logic [31:0] sys__stat_trn_cpt_tx,
  input  logic [31:0] sys__stat_trn_cpt_tx_drop,
  input  logic [31:0] sys__stat_trn_cpt_tx_start,
  input  logic [31:0] sys__tx_error,
  output logic [31:0] sys__bar_bitmap,
  output logic        sys__hm_start_read
);

  logic       sel, wr, busy, start_req;
  logic [3:0] reg_a;
  logic       unused_addr_bits;

  assign sel              = (csr_a[13:10] == csr_addr);
  assign reg_a            = csr_a[3:0];
  assign wr               = sel & csr_we;
  assign busy             = (sys__state != HM_STATE_IDLE);
  assign start_req        = wr && (reg_a == REG_CTRL) && csr_di[0];
  assign unused_addr_bits = ^csr_a[9:4];

  hm_status_t  status_q, status_d, status_set;
  logic [7:0]  w1c;
  logic [7:0]  irq_en_q, irq_en_d;
  logic [31:0] bar_q, bar_d;
  logic [4:0]  last_bar_q, last_bar_d;
  logic [31:0] csr_do_q, csr_do_d;
  logic        irq_q, irq_d;
  logic        start_q, start_d;
  logic        lnk_prev_q, lnk_prev_d;

  logic             clr0, clr1;
  logic [cnt_w-1:0] rx_to_cnt, tx_to_cnt, wr_to_cnt, hm_end_cnt;

  assign clr0 = wr && (reg_a == REG_CNT0);
  assign clr1 = wr && (reg_a == REG_CNT1);

  hm_evcnt #(.W(cnt_w)) u_cnt_rx_to (
    .clk(sys_clk), .rst(sys_rst), .inc(sys__rx_timeout), .clr(clr0), .cnt(rx_to_cnt)
  );
  hm_evcnt #(.W(cnt_w)) u_cnt_tx_to (
    .clk(sys_clk), .rst(sys_rst), .inc(sys__tx_timeout), .clr(clr0), .cnt(tx_to_cnt)
  );
  hm_evcnt #(.W(cnt_w)) u_cnt_wr_to (
    .clk(sys_clk), .rst(sys_rst), .inc(sys__wr_timeout), .clr(clr1), .cnt(wr_to_cnt)
  );
  hm_evcnt #(.W(cnt_w)) u_cnt_hm_end (
    .clk(sys_clk), .rst(sys_rst), .inc(sys__hm_end), .clr(clr1), .cnt(hm_end_cnt)
  );

  // An accepted start blocks a request in the very next cycle without flagging it.
  assign start_d = start_req && !busy && !start_q;

  always_comb begin
    status_set           = '0;
    status_set.rx_to     = sys__rx_timeout;
    status_set.tx_to     = sys__tx_timeout;
    status_set.wr_to     = sys__wr_timeout;
    status_set.hm_end    = sys__hm_end;
    status_set.write_bar = sys__write_bar;
    status_set.read_exp  = sys__read_exp;
    status_set.link_down = sys__trn_lnk_up_n && !lnk_prev_q;
    status_set.start_rej = start_req && busy;
    w1c      = (wr && (reg_a == REG_STATUS)) ? csr_di[7:0] : 8'h00;
    // Set wins over clear so an event coinciding with W1C is never lost.
    status_d = hm_status_t'((status_q & ~w1c) | status_set);
  end

  always_comb begin
    irq_en_d   = irq_en_q;
    bar_d      = bar_q;
    last_bar_d = last_bar_q;
    if (wr && (reg_a == REG_IRQ_EN))     irq_en_d = csr_di[7:0];
    if (wr && (reg_a == REG_BAR_BITMAP)) bar_d    = csr_di;
    if (sys__write_bar)                  last_bar_d = sys__write_bar_number;
    lnk_prev_d = sys__trn_lnk_up_n;
    irq_d      = |(status_q & irq_en_q);
  end

  always_comb begin
    csr_do_d = 32'h0;
    if (sel) begin
      case (reg_a)
        REG_CTRL:         csr_do_d = {31'b0, busy};
        REG_STATUS:       csr_do_d = {24'b0, status_q};
        REG_IRQ_EN:       csr_do_d = {24'b0, irq_en_q};
        REG_STATE:        csr_do_d = {24'b0, sys__state, sys__state_tx, sys__state_rx,
                                      ~sys__trn_lnk_up_n};
        REG_BAR_BITMAP:   csr_do_d = bar_q;
        REG_LAST_BAR:     csr_do_d = {27'b0, last_bar_q};
        REG_RX_TLP_DW:    csr_do_d = sys__rx_tlp_dw;
        REG_CPT_RX:       csr_do_d = sys__stat_trn_cpt_rx;
        REG_CPT_TX:       csr_do_d = sys__stat_trn_cpt_tx;
        REG_CPT_TX_DROP:  csr_do_d = sys__stat_trn_cpt_tx_drop;
        REG_CPT_TX_START: csr_do_d = sys__stat_trn_cpt_tx_start;
        REG_TX_ERROR:     csr_do_d = sys__tx_error;
        REG_CNT0:         csr_do_d = 32'({tx_to_cnt, rx_to_cnt});
        REG_CNT1:         csr_do_d = 32'({hm_end_cnt, wr_to_cnt});
        default:          csr_do_d = 32'h0;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      status_q   <= '0;
      irq_en_q   <= 8'h00;
      bar_q      <= 32'h0;
      last_bar_q <= 5'h0;
      csr_do_q   <= 32'h0;
      irq_q      <= 1'b0;
      start_q    <= 1'b0;
      lnk_prev_q <= 1'b0;
    end else begin
      status_q   <= status_d;
      irq_en_q   <= irq_en_d;
      bar_q      <= bar_d;
      last_bar_q <= last_bar_d;
      csr_do_q   <= csr_do_d;
      irq_q      <= irq_d;
      start_q    <= start_d;
      lnk_prev_q <= lnk_prev_d;
    end
  end

  assign csr_do             = csr_do_q;
  assign irq                = irq_q;
  assign sys__bar_bitmap    = bar_q;
  assign sys__hm_start_read = start_q;

endmodule

// File: tb/tb_hm_ctlif.sv
// Scoreboard bench for hm_ctlif: driver pushes model expectations, monitor compares.
// Directed test-plan sequence followed by randomized traffic and a mid-operation reset.
module tb_hm_ctlif;

  localparam logic [3:0] BANK = 4'h3;
  localparam int         CMAX = 65535;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [13:0] csr_a = 14'h0;
  logic        csr_we = 1'b0;
  logic [31:0] csr_di = 32'h0;
  logic [31:0] csr_do;
  logic        irq;
  logic        sys__rx_timeout = 1'b0, sys__tx_timeout = 1'b0, sys__wr_timeout = 1'b0;
  logic        sys__hm_end = 1'b0, sys__write_bar = 1'b0, sys__read_exp = 1'b0;
  logic        sys__trn_lnk_up_n = 1'b0;
  logic [2:0]  sys__state_rx = 3'h0;
  logic [1:0]  sys__state_tx = 2'h0;
  logic [1:0]  sys__state = 2'h0;
  logic [31:0] sys__rx_tlp_dw = 32'h0;
  logic [4:0]  sys__write_bar_number = 5'h0;
  logic [31:0] sys__stat_trn_cpt_rx = 32'h0, sys__stat_trn_cpt_tx = 32'h0;
  logic [31:0] sys__stat_trn_cpt_tx_drop = 32'h0, sys__stat_trn_cpt_tx_start = 32'h0;
  logic [31:0] sys__tx_error = 32'h0;
  logic [31:0] sys__bar_bitmap;
  logic        sys__hm_start_read;

  hm_ctlif #(.csr_addr(BANK), .cnt_w(16)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .csr_a(csr_a), .csr_we(csr_we), .csr_di(csr_di), .csr_do(csr_do), .irq(irq),
    .sys__rx_timeout(sys__rx_timeout), .sys__tx_timeout(sys__tx_timeout),
    .sys__wr_timeout(sys__wr_timeout), .sys__hm_end(sys__hm_end),
    .sys__write_bar(sys__write_bar), .sys__read_exp(sys__read_exp),
    .sys__trn_lnk_up_n(sys__trn_lnk_up_n), .sys__state_rx(sys__state_rx),
    .sys__state_tx(sys__state_tx), .sys__state(sys__state),
    .sys__rx_tlp_dw(sys__rx_tlp_dw), .sys__write_bar_number(sys__write_bar_number),
    .sys__stat_trn_cpt_rx(sys__stat_trn_cpt_rx), .sys__stat_trn_cpt_tx(sys__stat_trn_cpt_tx),
    .sys__stat_trn_cpt_tx_drop(sys__stat_trn_cpt_tx_drop),
    .sys__stat_trn_cpt_tx_start(sys__stat_trn_cpt_tx_start),
    .sys__tx_error(sys__tx_error), .sys__bar_bitmap(sys__bar_bitmap),
    .sys__hm_start_read(sys__hm_start_read)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [31:0] rdat;
    logic        irq;
    logic        start;
    logic [31:0] bar;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state, kept as plain integers and bytes.
  logic [7:0]  m_status, m_irq_en;
  logic [31:0] m_bar;
  logic [4:0]  m_last_bar;
  logic        m_lnk_prev, m_start_prev;
  int          m_cnt[4];

  task automatic model_reset();
    m_status = 8'h0; m_irq_en = 8'h0; m_bar = 32'h0; m_last_bar = 5'h0;
    m_lnk_prev = 1'b0; m_start_prev = 1'b0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  function automatic int bump(int c, logic clr, logic ev);
    if (clr) return ev ? 1 : 0;
    if (ev) return (c >= CMAX) ? CMAX : c + 1;
    return c;
  endfunction

  function automatic logic [31:0] model_read(logic [3:0] r);
    logic [15:0] lo, hi;
    case (r)
      4'h0: return {31'b0, sys__state != 2'd0};
      4'h1: return {24'b0, m_status};
      4'h2: return {24'b0, m_irq_en};
      4'h3: return {24'b0, sys__state, sys__state_tx, sys__state_rx, ~sys__trn_lnk_up_n};
      4'h4: return m_bar;
      4'h5: return {27'b0, m_last_bar};
      4'h6: return sys__rx_tlp_dw;
      4'h7: return sys__stat_trn_cpt_rx;
      4'h8: return sys__stat_trn_cpt_tx;
      4'h9: return sys__stat_trn_cpt_tx_drop;
      4'hA: return sys__stat_trn_cpt_tx_start;
      4'hB: return sys__tx_error;
      4'hC: begin lo = 16'(m_cnt[0]); hi = 16'(m_cnt[1]); return {hi, lo}; end
      4'hD: begin lo = 16'(m_cnt[2]); hi = 16'(m_cnt[3]); return {hi, lo}; end
      default: return 32'h0;
    endcase
  endfunction

  // Predicts what the DUT shows after the coming edge, then advances the model.
  task automatic model_step();
    exp_t       e;
    logic       s, wr, busy, req, acc;
    logic [3:0] r;
    logic [7:0] ev, w1c;
    s    = (csr_a[13:10] == BANK);
    r    = csr_a[3:0];
    wr   = s && csr_we;
    busy = (sys__state != 2'd0);
    req  = wr && (r == 4'h0) && csr_di[0];
    acc  = req && !busy && !m_start_prev;
    e.rdat  = s ? model_read(r) : 32'h0;
    e.irq   = |(m_status & m_irq_en);
    e.start = acc;
    ev  = {req && busy, sys__trn_lnk_up_n && !m_lnk_prev, sys__read_exp, sys__write_bar,
           sys__hm_end, sys__wr_timeout, sys__tx_timeout, sys__rx_timeout};
    w1c = (wr && r == 4'h1) ? csr_di[7:0] : 8'h0;
    m_status = (m_status & ~w1c) | ev;
    if (wr && r == 4'h2) m_irq_en = csr_di[7:0];
    if (wr && r == 4'h4) m_bar = csr_di;
    if (sys__write_bar) m_last_bar = sys__write_bar_number;
    m_cnt[0] = bump(m_cnt[0], wr && r == 4'hC, sys__rx_timeout);
    m_cnt[1] = bump(m_cnt[1], wr && r == 4'hC, sys__tx_timeout);
    m_cnt[2] = bump(m_cnt[2], wr && r == 4'hD, sys__wr_timeout);
    m_cnt[3] = bump(m_cnt[3], wr && r == 4'hD, sys__hm_end);
    m_lnk_prev   = sys__trn_lnk_up_n;
    m_start_prev = acc;
    e.bar = m_bar;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    model_step();
    @(negedge sys_clk);
    csr_we = 1'b0; csr_a = 14'h0; csr_di = 32'h0;
    sys__rx_timeout = 1'b0; sys__tx_timeout = 1'b0; sys__wr_timeout = 1'b0;
    sys__hm_end = 1'b0; sys__write_bar = 1'b0; sys__read_exp = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic csr_wr(input logic [3:0] r, input logic [31:0] d);
    csr_a = {BANK, 6'($urandom), r}; csr_we = 1'b1; csr_di = d;
    tick();
  endtask

  task automatic csr_rd(input logic [3:0] r);
    csr_a = {BANK, 6'($urandom), r}; csr_we = 1'b0; csr_di = $urandom;
    tick();
  endtask

  task automatic randomize_passthru();
    sys__rx_tlp_dw = $urandom; sys__stat_trn_cpt_rx = $urandom;
    sys__stat_trn_cpt_tx = $urandom; sys__stat_trn_cpt_tx_drop = $urandom;
    sys__stat_trn_cpt_tx_start = $urandom; sys__tx_error = $urandom;
    sys__state_rx = 3'($urandom); sys__state_tx = 2'($urandom);
  endtask

  always @(posedge sys_clk) begin : monitor
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (csr_do !== e.rdat) begin
        miscompares++;
        $display("FAIL csr_do @%0t: got %08h want %08h", $time, csr_do, e.rdat);
      end
      if (irq !== e.irq) begin
        miscompares++;
        $display("FAIL irq @%0t: got %0b want %0b", $time, irq, e.irq);
      end
      if (sys__hm_start_read !== e.start) begin
        miscompares++;
        $display("FAIL start_read @%0t: got %0b want %0b", $time, sys__hm_start_read, e.start);
      end
      if (sys__bar_bitmap !== e.bar) begin
        miscompares++;
        $display("FAIL bar_bitmap @%0t: got %08h want %08h", $time, sys__bar_bitmap, e.bar);
      end
    end
  end

  initial begin
    model_reset();
    randomize_passthru();
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;

    for (int i = 0; i < 16; i++) csr_rd(4'(i));

    csr_wr(4'h4, 32'hA5A5_0003);
    csr_rd(4'h4);

    sys__state = 2'd0;
    idle(1);
    csr_wr(4'h0, 32'h1);
    idle(2);
    sys__state = 2'd2;
    csr_wr(4'h0, 32'h1);
    csr_rd(4'h1);
    csr_rd(4'h0);
    sys__state = 2'd0;
    csr_wr(4'h1, 32'hFF);
    idle(1);
    csr_wr(4'h0, 32'h1);
    csr_wr(4'h0, 32'h1);
    csr_rd(4'h1);

    repeat (3) begin sys__rx_timeout = 1'b1; tick(); end
    sys__tx_timeout = 1'b1; tick();
    csr_rd(4'hC);
    sys__rx_timeout = 1'b1;
    csr_wr(4'hC, 32'h0);
    csr_rd(4'hC);

    csr_wr(4'h1, 32'hFF);
    csr_wr(4'h2, 32'h08);
    sys__hm_end = 1'b1; tick();
    csr_rd(4'h1);
    idle(2);
    csr_wr(4'h1, 32'h08);
    idle(2);
    sys__hm_end = 1'b1; tick();
    idle(2);
    sys__hm_end = 1'b1;
    csr_wr(4'h1, 32'h08);
    csr_rd(4'h1);
    idle(2);

    repeat (70000) begin sys__wr_timeout = 1'b1; tick(); end
    csr_rd(4'hD);
    sys__write_bar = 1'b1; sys__write_bar_number = 5'd17; tick();
    csr_rd(4'h5);
    csr_rd(4'h1);
    sys__trn_lnk_up_n = 1'b1; tick();
    csr_rd(4'h1);
    csr_rd(4'h3);

    for (int n = 0; n < 3000; n++) begin
      csr_a  = {(($urandom_range(0, 3) != 0) ? BANK : 4'($urandom)), 6'($urandom), 4'($urandom)};
      csr_we = ($urandom_range(0, 2) == 0);
      csr_di = ($urandom_range(0, 1) == 0) ? 32'h1 : $urandom;
      sys__rx_timeout = ($urandom_range(0, 7) == 0);
      sys__tx_timeout = ($urandom_range(0, 7) == 0);
      sys__wr_timeout = ($urandom_range(0, 7) == 0);
      sys__hm_end     = ($urandom_range(0, 7) == 0);
      sys__write_bar  = ($urandom_range(0, 7) == 0);
      sys__read_exp   = ($urandom_range(0, 7) == 0);
      sys__write_bar_number = 5'($urandom);
      if ($urandom_range(0, 49) == 0) sys__trn_lnk_up_n = ~sys__trn_lnk_up_n;
      if ($urandom_range(0, 9) == 0) sys__state = 2'($urandom);
      if ($urandom_range(0, 19) == 0) randomize_passthru();
      tick();
    end

    sys__state = 2'd0;
    sys__trn_lnk_up_n = 1'b0;
    idle(2);
    csr_wr(4'h2, 32'hFF);
    csr_wr(4'h4, 32'hFFFF_FFFF);
    csr_wr(4'h0, 32'h1);
    sys_rst = 1'b1;
    #1;
    vectors++;
    if (sys__hm_start_read !== 1'b0 || irq !== 1'b0 || csr_do !== 32'h0 ||
        sys__bar_bitmap !== 32'h0) begin
      miscompares++;
      $display("FAIL async_reset: start=%0b irq=%0b do=%08h bar=%08h want all 0",
               sys__hm_start_read, irq, csr_do, sys__bar_bitmap);
    end
    model_reset();
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    csr_rd(4'h4);
    csr_rd(4'h1);
    csr_rd(4'hC);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
